// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared states, row codes and jump-table defaults
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam int unsigned PC_W_DEF  = 8;
    localparam int unsigned ROW_W_DEF = 3;

    localparam logic [2:0] ROW_ZERO   = 3'd0;
    localparam logic [2:0] ROW_ONE    = 3'd1;
    localparam logic [2:0] ROW_THIRTY = 3'd2;
    localparam logic [2:0] ROW_SIXTY  = 3'd3;

    localparam logic [7:0] DEF_ZERO   = 8'd0;
    localparam logic [7:0] DEF_ONE    = 8'd1;
    localparam logic [7:0] DEF_THIRTY = 8'd30;
    localparam logic [7:0] DEF_SIXTY  = 8'd60;

    // Rows beyond the four named codes come out of reset as zero.
    function automatic logic [7:0] default_entry(input int unsigned row);
        logic [7:0] val;
        val = 8'd0;
        if (row == 32'(ROW_ZERO))   val = DEF_ZERO;
        if (row == 32'(ROW_ONE))    val = DEF_ONE;
        if (row == 32'(ROW_THIRTY)) val = DEF_THIRTY;
        if (row == 32'(ROW_SIXTY))  val = DEF_SIXTY;
        return val;
    endfunction

endpackage

// File: rtl/pc_sequencer_jump_lut.sv
// rtl/pc_sequencer_jump_lut.sv - writable jump-target table, async read, sync write
module jump_lut
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             cfg_we,
    input  logic [ROW_W-1:0] cfg_row,
    input  logic [PC_W-1:0]  cfg_data,
    input  logic [ROW_W-1:0] rd_row,
    output logic [PC_W-1:0]  rd_data
);

    localparam int unsigned ROWS = 2 ** ROW_W;

    logic [PC_W-1:0] table_q [ROWS];
    logic [PC_W-1:0] table_d [ROWS];

    // Read comes from the registered table, so a same-cycle write is not visible yet.
    assign rd_data = table_q[rd_row];

    always_comb begin
        table_d = table_q;
        if (cfg_we) begin
            table_d[cfg_row] = cfg_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                table_q[i] <= PC_W'(default_entry(i));
            end
        end else begin
            table_q <= table_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, run/halt FSM and next-PC mux
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchAbs,
    input  logic             BranchRel,
    input  logic             Taken,
    input  logic [ROW_W-1:0] Row,
    input  logic             CfgWe,
    input  logic [ROW_W-1:0] CfgRow,
    input  logic [PC_W-1:0]  CfgData,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done
);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_data;

    jump_lut #(
        .PC_W  (PC_W),
        .ROW_W (ROW_W)
    ) u_jump_lut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .cfg_we   (CfgWe),
        .cfg_row  (CfgRow),
        .cfg_data (CfgData),
        .rd_row   (Row),
        .rd_data  (lut_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = HALTED;
                end else if (!Stall) begin
                    // Relative add is two's complement; truncation gives the wrap.
                    if (BranchAbs && Taken) begin
                        pc_d = lut_data;
                    end else if (BranchRel && Taken) begin
                        pc_d = pc_q + lut_data;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign PC      = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic       Clk;
    logic       Reset_n;
    logic       Start, Halt, Stall, BranchAbs, BranchRel, Taken;
    logic [2:0] Row;
    logic       CfgWe;
    logic [2:0] CfgRow;
    logic [7:0] CfgData;
    logic [7:0] PC;
    logic       Running, Done;

    int n_cmp;
    int n_fail;

    pc_sequencer #(.PC_W(8), .ROW_W(3)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Halt      (Halt),
        .Stall     (Stall),
        .BranchAbs (BranchAbs),
        .BranchRel (BranchRel),
        .Taken     (Taken),
        .Row       (Row),
        .CfgWe     (CfgWe),
        .CfgRow    (CfgRow),
        .CfgData   (CfgData),
        .PC        (PC),
        .Running   (Running),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        Start = 0; Halt = 0; Stall = 0; BranchAbs = 0; BranchRel = 0; Taken = 0;
        Row = 0; CfgWe = 0; CfgRow = 0; CfgData = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] d);
        CfgWe = 1; CfgRow = r; CfgData = d;
        step();
        CfgWe = 0;
    endtask

    // Loads row 7 then jumps through it; requires RUN.
    task automatic goto_pc(input logic [7:0] v);
        write_row(3'd7, v);
        BranchAbs = 1; Taken = 1; Row = 3'd7;
        step();
        BranchAbs = 0; Taken = 0; Row = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset_n = 0;
        step();
        step();
        Reset_n = 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (PC !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", PC); end
        n_cmp++; if (Running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", Running); end
        n_cmp++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
        step();
        n_cmp++; if (PC !== 8'd0 || Running !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got pc=%0d run=%b want 0/0", PC, Running); end
    endtask

    task automatic test_start();
        logic [7:0] exp_pc [5];
        exp_pc = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        Start = 1;
        step();
        Start = 0;
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b want 1", Running); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (PC !== exp_pc[i]) begin n_fail++; $display("FAIL start_seq[%0d]: got %0d want %0d", i, PC, exp_pc[i]); end
            step();
        end
        Start = 1;
        step();
        Start = 0;
        n_cmp++; if (PC !== 8'd6) begin n_fail++; $display("FAIL start_ignored_in_run: got %0d want 6", PC); end
    endtask

    task automatic test_abs_branch();
        goto_pc(8'd10);
        n_cmp++; if (PC !== 8'd10) begin n_fail++; $display("FAIL goto10: got %0d want 10", PC); end
        BranchAbs = 1; Taken = 1; Row = 3'd3;
        step();
        n_cmp++; if (PC !== 8'd60) begin n_fail++; $display("FAIL abs_taken: got %0d want 60", PC); end
        goto_pc(8'd10);
        BranchAbs = 1; Taken = 0; Row = 3'd3;
        step();
        n_cmp++; if (PC !== 8'd11) begin n_fail++; $display("FAIL abs_not_taken: got %0d want 11", PC); end
        goto_pc(8'd10);
        BranchAbs = 1; BranchRel = 1; Taken = 1; Row = 3'd3;
        step();
        BranchAbs = 0; BranchRel = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd60) begin n_fail++; $display("FAIL abs_over_rel: got %0d want 60", PC); end
    endtask

    task automatic test_rel_branch();
        write_row(3'd5, 8'hE2);
        goto_pc(8'd40);
        BranchRel = 1; Taken = 1; Row = 3'd5;
        step();
        BranchRel = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd10) begin n_fail++; $display("FAIL rel_neg: got %0d want 10", PC); end
        write_row(3'd4, 8'd10);
        goto_pc(8'd250);
        BranchRel = 1; Taken = 1; Row = 3'd4;
        step();
        BranchRel = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd4) begin n_fail++; $display("FAIL rel_wrap: got %0d want 4", PC); end
    endtask

    task automatic test_wrap_and_stall();
        goto_pc(8'd255);
        step();
        n_cmp++; if (PC !== 8'd0) begin n_fail++; $display("FAIL inc_wrap: got %0d want 0", PC); end
        goto_pc(8'd7);
        Stall = 1; BranchAbs = 1; Taken = 1; Row = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (PC !== 8'd7) begin n_fail++; $display("FAIL stall[%0d]: got %0d want 7", i, PC); end
        end
        Stall = 0; BranchAbs = 0; Taken = 0;
        step();
        n_cmp++; if (PC !== 8'd8) begin n_fail++; $display("FAIL stall_release: got %0d want 8", PC); end
    endtask

    task automatic test_write_same_cycle();
        CfgWe = 1; CfgRow = 3'd6; CfgData = 8'd100;
        BranchAbs = 1; Taken = 1; Row = 3'd6;
        step();
        CfgWe = 0;
        n_cmp++; if (PC !== 8'd0) begin n_fail++; $display("FAIL write_old_value: got %0d want 0", PC); end
        step();
        BranchAbs = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd100) begin n_fail++; $display("FAIL write_new_value: got %0d want 100", PC); end
    endtask

    task automatic test_halt();
        goto_pc(8'd20);
        Halt = 1; Stall = 1;
        step();
        Halt = 0; Stall = 0;
        n_cmp++; if (Done !== 1'b1 || Running !== 1'b0) begin n_fail++; $display("FAIL halt_flags: got done=%b run=%b want 1/0", Done, Running); end
        n_cmp++; if (PC !== 8'd20) begin n_fail++; $display("FAIL halt_pc: got %0d want 20", PC); end
        write_row(3'd2, 8'd77);
        step();
        n_cmp++; if (PC !== 8'd20 || Done !== 1'b1) begin n_fail++; $display("FAIL halted_hold: got pc=%0d done=%b want 20/1", PC, Done); end
        BranchAbs = 1; Taken = 1; Row = 3'd2;
        step();
        BranchAbs = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd20) begin n_fail++; $display("FAIL halted_branch: got %0d want 20", PC); end
        Start = 1;
        step();
        Start = 0;
        n_cmp++; if (PC !== 8'd0 || Running !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL restart: got pc=%0d run=%b done=%b want 0/1/0", PC, Running, Done); end
        BranchAbs = 1; Taken = 1; Row = 3'd2;
        step();
        BranchAbs = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd77) begin n_fail++; $display("FAIL halted_cfg_write: got %0d want 77", PC); end
    endtask

    task automatic test_reset_mid_run();
        write_row(3'd1, 8'd99);
        goto_pc(8'd33);
        n_cmp++; if (PC !== 8'd33) begin n_fail++; $display("FAIL goto33: got %0d want 33", PC); end
        #2;
        Reset_n = 0;
        #1;
        n_cmp++; if (PC !== 8'd0 || Running !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc=%0d run=%b done=%b want 0/0/0", PC, Running, Done); end
        step();
        Reset_n = 1;
        step();
        step();
        n_cmp++; if (PC !== 8'd0 || Running !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got pc=%0d run=%b want 0/0", PC, Running); end
        Start = 1;
        step();
        Start = 0;
        BranchAbs = 1; Taken = 1; Row = 3'd1;
        step();
        BranchAbs = 0; Taken = 0;
        n_cmp++; if (PC !== 8'd1) begin n_fail++; $display("FAIL table_restored: got %0d want 1", PC); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        Reset_n = 1;
        clear_inputs();
        test_reset();
        test_start();
        test_abs_branch();
        test_rel_branch();
        test_wrap_and_stall();
        test_write_same_cycle();
        test_halt();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
